// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/ack bus between fetch_stage (master) and memory (slave)
//   imemReq  : request valid, held with imemAddr until imemAck
//   imemAddr : 16-bit fetch address
//   imemAck  : response valid this cycle
//   imemData : fetched instruction, valid with imemAck
interface fetch_stage_if;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck;
  logic [15:0] imemData;
  modport master (output imemReq, imemAddr, input imemAck, imemData);
  modport slave  (input imemReq, imemAddr, output imemAck, imemData);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: 16-bit pipeline fetch stage with one-outstanding imem handshake, stall, redirect and HALT
//   clk, rst (async active-low), stall, redirect, redirectPC : control from clock/reset, hazard unit, branch unit
//   imem (fetch_stage_if.master) : instruction memory bus
//   PCCurr, PCInc, Inst, instValid : IF/ID bundle; halted : HALT fetched
//   FETCH_PERF_CNT_EN adds saturating fetchCount/bubbleCount outputs
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [15:0]   redirectPC,
  fetch_stage_if.master imem,
  output logic [15:0]   PCCurr,
  output logic [15:0]   PCInc,
  output logic [15:0]   Inst,
  output logic          instValid,
  output logic          halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]   fetchCount,
  output logic [15:0]   bubbleCount
`endif
);
  localparam logic [1:0] REQ = 2'd0, DRAIN = 2'd1, HALTED = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d, addr_q, addr_d, pc_curr_q, pc_curr_d, pc_inc_q, pc_inc_d, inst_q, inst_d;
  logic        pending_q, pending_d, valid_q, valid_d;
  logic        consume, accept;
  always_comb begin
    // A raised request is held (pending_q) so stall cannot drop it before the ack
    imem.imemReq  = rst && state_q != HALTED && (pending_q || !valid_q || !stall);
    imem.imemAddr = pending_q ? addr_q : pc_q;
    consume = valid_q && !stall;
    // Ack data is kept only when the buffer is free; otherwise the same pc is refetched later
    accept  = state_q == REQ && imem.imemReq && imem.imemAck && !redirect && (!valid_q || !stall);
    state_d = redirect ? ((imem.imemReq && !imem.imemAck) ? DRAIN : REQ) :
              (state_q == DRAIN && imem.imemAck) ? REQ :
              (accept && imem.imemData[15:11] == 5'b00000) ? HALTED : state_q;
    pc_d      = redirect ? redirectPC : accept ? pc_q + 16'd2 : pc_q;
    valid_d   = redirect ? 1'b0 : accept ? 1'b1 : consume ? 1'b0 : valid_q;
    pc_curr_d = accept ? pc_q : pc_curr_q;
    pc_inc_d  = accept ? pc_q + 16'd2 : pc_inc_q;
    inst_d    = accept ? imem.imemData : inst_q;
    pending_d = imem.imemReq && !imem.imemAck;
    addr_d    = imem.imemAddr;
    PCCurr    = pc_curr_q;
    PCInc     = pc_inc_q;
    Inst      = valid_q ? inst_q : NOP_INST;
    instValid = valid_q;
    halted    = state_q == HALTED;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      pc_curr_q <= 16'h0000;
      pc_inc_q  <= 16'h0000;
      inst_q    <= NOP_INST;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      pc_curr_q <= pc_curr_d;
      pc_inc_q  <= pc_inc_d;
      inst_q    <= inst_d;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;
  always_comb begin
    fetch_cnt_d  = (consume && fetch_cnt_q != 16'hFFFF) ? fetch_cnt_q + 16'd1 : fetch_cnt_q;
    bubble_cnt_d = (!valid_q && state_q != HALTED && bubble_cnt_q != 16'hFFFF) ? bubble_cnt_q + 16'd1 : bubble_cnt_q;
    fetchCount   = fetch_cnt_q;
    bubbleCount  = bubble_cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q  <= 16'h0000;
      bubble_cnt_q <= 16'h0000;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a variable-latency memory model
module tb_fetch_stage;
  logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] pc_curr, pc_inc, inst;
  logic        inst_valid, halted;
  int          lat = 0, wcnt = 0, n_checks = 0, n_fail = 0;
  fetch_stage_if bus();
  always #5 clk = ~clk;
  function automatic logic [15:0] mem(input logic [15:0] a);
    return a == 16'h0020 ? 16'h0000 : 16'hC000 + (a >> 1) + 16'h0001;
  endfunction
  assign bus.imemAck  = bus.imemReq && wcnt == lat;
  assign bus.imemData = bus.imemAck ? mem(bus.imemAddr) : 16'hDEAD;
  always @(posedge clk) wcnt <= (!bus.imemReq || bus.imemAck) ? 0 : wcnt + 1;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count, bubble_count;
  int exp_fetch = 0;
  always @(posedge clk) if (rst && inst_valid && !stall) exp_fetch <= exp_fetch + 1;
`endif
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPC(redirect_pc),
    .imem(bus.master), .PCCurr(pc_curr), .PCInc(pc_inc), .Inst(inst),
    .instValid(inst_valid), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .fetchCount(fetch_count), .bubbleCount(bubble_count)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic bundle(input string tag, input logic [15:0] pc, input logic [15:0] ins);
    check({tag, "_pc"}, pc_curr, pc);
    check({tag, "_inst"}, inst, ins);
    check({tag, "_valid"}, inst_valid, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", bus.imemReq, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 16'h0800);
    check("rst_pc", {pc_curr, pc_inc}, 0);
    check("rst_halt", halted, 0);
    rst = 1'b1; #1;
    check("first_req", {bus.imemReq, bus.imemAddr}, {1'b1, 16'h0000});
    check("pre_inst", inst, 16'h0800);
    @(negedge clk); bundle("i0", 16'h0000, 16'hC001);
    check("i0_inc", pc_inc, 16'h0002);
    @(negedge clk); bundle("i1", 16'h0002, 16'hC002);
    stall = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      check("stall_req", bus.imemReq, 0);
      @(negedge clk); bundle("stall_hold", 16'h0002, 16'hC002);
    end
    check("stall_req_end", bus.imemReq, 0);
    stall = 1'b0;
    @(negedge clk); bundle("after_stall", 16'h0004, 16'hC003);
    lat = 2; #1;
    for (int i = 0; i < 3; i++) begin
      check("wait_addr", {bus.imemReq, bus.imemAddr}, {1'b1, 16'h0006});
      if (i > 0) check("bubble", {inst_valid, inst}, {1'b0, 16'h0800});
      @(negedge clk);
    end
    bundle("after_wait", 16'h0006, 16'hC004);
    lat = 1; redirect = 1'b1; redirect_pc = 16'h0010;
    @(negedge clk); redirect = 1'b0;
    check("drain1_addr", {bus.imemReq, bus.imemAddr, inst_valid}, {1'b1, 16'h0008, 1'b0});
    @(negedge clk);
    check("req10_addr", {bus.imemReq, bus.imemAddr, inst_valid}, {1'b1, 16'h0010, 1'b0});
    redirect = 1'b1; redirect_pc = 16'h0100;
    @(negedge clk); redirect = 1'b0;
    check("drain2_addr", {bus.imemReq, bus.imemAddr, inst_valid}, {1'b1, 16'h0010, 1'b0});
    @(negedge clk);
    check("req100_addr", {bus.imemReq, bus.imemAddr, inst_valid}, {1'b1, 16'h0100, 1'b0});
    @(negedge clk);
    check("drain_bubble", {inst_valid, inst}, {1'b0, 16'h0800});
    @(negedge clk); bundle("redir", 16'h0100, 16'hC081);
    lat = 0; redirect = 1'b1; redirect_pc = 16'h001E;
    @(negedge clk); redirect = 1'b0;
    check("redir_gap", {inst_valid, bus.imemAddr}, {1'b0, 16'h001E});
    @(negedge clk); bundle("pre_halt", 16'h001E, 16'hC010);
    @(negedge clk); bundle("halt_inst", 16'h0020, 16'h0000);
    check("halt_flag", {halted, bus.imemReq}, {1'b1, 1'b0});
    @(negedge clk);
    check("halt_consumed", {halted, bus.imemReq, inst_valid, inst}, {1'b1, 1'b0, 1'b0, 16'h0800});
    @(negedge clk);
    check("halt_idle", {halted, bus.imemReq}, {1'b1, 1'b0});
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk); redirect = 1'b0;
    check("resume", {halted, bus.imemReq, bus.imemAddr}, {1'b0, 1'b1, 16'h0040});
    @(negedge clk); bundle("resume_inst", 16'h0040, 16'hC021);
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    @(negedge clk); redirect = 1'b0;
    check("wrap_req", bus.imemAddr, 16'hFFFE);
    @(negedge clk); bundle("wrap", 16'hFFFE, 16'h4000);
    check("wrap_inc", pc_inc, 16'h0000);
    check("wrap_next_addr", bus.imemAddr, 16'h0000);
    @(negedge clk); bundle("wrapped", 16'h0000, 16'hC001);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, exp_fetch);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipeline. It owns the program counter, runs a one-outstanding-request handshake with a variable-latency instruction memory, and presents {PCCurr, PCInc, Inst} plus a valid flag to the IF/ID pipeline register. It also absorbs hazard-unit stalls and branch/jump redirects from later stages, and stops fetching on HALT.

## Interface
Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.
- NOP_INST, 16'h0800: instruction driven on Inst whenever instValid=0.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-low.
- stall  in  1  hazard unit holds the IF/ID register this cycle.
- redirect  in  1  taken branch/jump; replaces the PC.
- redirectPC  in  16  target for redirect.
- imemReq  out  1  instruction memory request.
- imemAddr  out  16  request address.
- imemAck  in  1  memory response valid this cycle.
- imemData  in  16  fetched instruction, valid with imemAck.
- PCCurr  out  16  address of the presented instruction.
- PCInc  out  16  PCCurr+2.
- Inst  out  16  presented instruction, or NOP_INST when invalid.
- instValid  out  1  output bundle holds a real instruction.
- halted  out  1  HALT fetched; fetch has stopped.

## Operation
- State: pc register, a one-entry output buffer {PCCurr, PCInc, Inst, instValid}, and FSM {REQ, DRAIN, HALTED}.
- Consume event: instValid=1 and stall=0 at a rising edge. IF/ID latches the bundle on that edge.
- REQ:
  - imemReq=1 when the buffer is empty or being consumed this cycle (instValid=0 or stall=0); imemAddr=pc.
  - Once raised, imemReq and imemAddr stay stable until imemAck, even if stall rises.
  - On imemAck with no redirect: buffer <= {pc, pc+2, imemData}, instValid<=1, pc<=pc+2.
  - If imemData[15:11]==5'b00000 (HALT), go to HALTED.
- HALTED: imemReq=0, halted=1. The HALT instruction stays presented until consumed. Only redirect or reset leaves this state.
- Redirect (priority over stall and ack):
  - pc<=redirectPC, instValid<=0, halted<=0.
  - If a request is pending without imemAck this cycle, go to DRAIN. Otherwise go to REQ.
  - Data acked in the same cycle as redirect is discarded.
- DRAIN: keep imemReq=1 with the old address until imemAck, discard the data, then go to REQ. A further redirect during DRAIN only updates pc.
- Arithmetic: pc+2 is modulo 2^16, so 16'hFFFE wraps to 16'h0000.

## Timing
- Reset (asynchronous, rst=0): pc=RESET_PC, FSM=REQ, instValid=0, halted=0, PCCurr=16'h0000, PCInc=16'h0000, Inst=NOP_INST. imemReq is combinationally 0 while rst=0.
- First request: imemReq=1 in the first cycle after rst deasserts.
- Latency: zero-wait memory (ack in the request cycle) gives instValid one edge after the request, and 1 instruction/cycle sustained when stall=0.
- An N-cycle memory wait adds N bubbles (NOP_INST, instValid=0).
- Stall with a full buffer: the bundle is held unchanged and no new request is issued. A request already in flight still completes; its data updates the buffer only if the buffer was consumed.
- Redirect to first valid instruction: two edges with zero-wait memory. With DRAIN, add the remaining wait of the old request.
- Reset mid-transaction: the outstanding request is abandoned. Memory must tolerate imemReq dropping.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds outputs fetchCount[15:0] and bubbleCount[15:0].
  - fetchCount increments on each consume event.
  - bubbleCount increments on each cycle with instValid=0 and state≠HALTED.
  - Both counters saturate at 16'hFFFF and reset to 0.
- FETCH_PERF_CNT_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset release, zero-wait memory returning 16'hC001 at 0x0000 and 16'hC002 at 0x0002 -> edges 1,2 present PCCurr=0x0000/PCInc=0x0002/Inst=16'hC001, then PCCurr=0x0002/Inst=16'hC002; Inst=16'h0800 before the first edge.
- Memory with 3-cycle ack latency -> imemAddr stable for 3 cycles; 2 bubble cycles with Inst=16'h0800 between instructions.
- stall=1 for 4 cycles with a full buffer -> bundle unchanged, no new imemReq; the next instruction appears one edge after stall falls.
- redirect=1, redirectPC=16'h0100 while a 2-cycle request to 0x0010 is pending -> DRAIN; 0x0010 data never appears; next valid PCCurr=0x0100.
- Fetch 16'h0000 at 0x0020 -> halted=1, no further imemReq; redirect to 0x0040 resumes fetch from 0x0040.
- pc=16'hFFFE fetched -> PCInc=16'h0000 and the next request address is 0x0000; with FETCH_PERF_CNT_EN, fetchCount matches the number of consume events.
